// File: rtl/arb_pkg.sv
`default_nettype none
// arb_pkg: state encoding and credit width shared by the arb_wrr2 arbiter and its pipeline.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  localparam int CREDIT_W = 4;

endpackage
`default_nettype wire

// File: rtl/arb_pipe.sv
`default_nettype none
// arb_pipe: two-stage valid/select/data pipeline turning issued pops into downstream pushes.
module arb_pipe #(
  parameter int DATA_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pop_0,
  input  logic                 pop_1,
  input  logic [DATA_SIZE-1:0] in0,
  input  logic [DATA_SIZE-1:0] in1,
  output logic                 push,
  output logic [DATA_SIZE-1:0] out
);

  logic stage_valid;
  logic stage_sel;

  // Stage 1 remembers which FIFO was popped; stage 2 captures that FIFO's read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_valid <= 1'b0;
      stage_sel   <= 1'b0;
      push        <= 1'b0;
      out         <= '0;
    end else begin
      stage_valid <= pop_0 | pop_1;
      stage_sel   <= pop_1;
      push        <= stage_valid;
      if (stage_valid) begin
        out <= stage_sel ? in1 : in0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb_wrr2.sv
`default_nettype none
// arb_wrr2: weighted round-robin scheduler popping two VC FIFOs into one downstream FIFO.
module arb_wrr2
  import arb_pkg::*;
#(
  parameter int DATA_SIZE = 10,
  parameter int WEIGHT0   = 2,
  parameter int WEIGHT1   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo0_empty,
  input  logic                 fifo1_empty,
  input  logic [DATA_SIZE-1:0] in0,
  input  logic [DATA_SIZE-1:0] in1,
  input  logic                 fifo_down_almostfull,
  output logic                 pop_0,
  output logic                 pop_1,
  output logic                 push,
  output logic [DATA_SIZE-1:0] out,
  output logic                 active
);

  localparam logic [CREDIT_W-1:0] W0 = CREDIT_W'(WEIGHT0);
  localparam logic [CREDIT_W-1:0] W1 = CREDIT_W'(WEIGHT1);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n;
  logic                last, last_n;
  logic                pop0_n, pop1_n;

  logic ok, can0, can1;
  logic cur, can_cur, can_oth;

  assign ok      = !fifo_down_almostfull;
  assign can0    = ok && !fifo0_empty;
  assign can1    = ok && !fifo1_empty;
  assign cur     = (state == SERVE1);
  assign can_cur = cur ? can1 : can0;
  assign can_oth = cur ? can0 : can1;

  always_comb begin
    state_n  = state;
    credit_n = credit;
    last_n   = last;
    pop0_n   = 1'b0;
    pop1_n   = 1'b0;
    case (state)
      IDLE: begin
        if (can0 && (!can1 || last)) begin
          state_n  = SERVE0;
          credit_n = W0;
          last_n   = 1'b0;
        end else if (can1) begin
          state_n  = SERVE1;
          credit_n = W1;
          last_n   = 1'b1;
        end
      end
      SERVE0, SERVE1: begin
        // Almost-full freezes state and credit; nothing below runs.
        if (ok) begin
          if (can_cur && credit != '0) begin
            pop0_n   = !cur;
            pop1_n   = cur;
            credit_n = credit - CREDIT_W'(1);
          end
          // Turn ends when this pop spends the last credit or the VC cannot be popped.
          if (!(can_cur && credit > CREDIT_W'(1))) begin
            if (can_oth) begin
              state_n  = cur ? SERVE0 : SERVE1;
              credit_n = cur ? W0 : W1;
              last_n   = !cur;
            end else if (can_cur) begin
              credit_n = cur ? W1 : W0;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      credit <= '0;
      last   <= 1'b1;
      pop_0  <= 1'b0;
      pop_1  <= 1'b0;
      active <= 1'b0;
    end else begin
      state  <= state_n;
      credit <= credit_n;
      last   <= last_n;
      pop_0  <= pop0_n;
      pop_1  <= pop1_n;
      active <= (state_n != IDLE);
    end
  end

  arb_pipe #(
    .DATA_SIZE(DATA_SIZE)
  ) u_pipe (
    .clk   (clk),
    .reset (reset),
    .pop_0 (pop_0),
    .pop_1 (pop_1),
    .in0   (in0),
    .in1   (in1),
    .push  (push),
    .out   (out)
  );

endmodule
`default_nettype wire

// File: tb/tb_arb_wrr2.sv
`default_nettype none
// tb_arb_wrr2: directed self-checking bench for the arb_wrr2 weighted round-robin arbiter.
module tb_arb_wrr2;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo0_empty, fifo1_empty, af;
  logic [9:0] in0, in1;
  logic       pop_0, pop_1, push, active;
  logic [9:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  arb_wrr2 #(.DATA_SIZE(10), .WEIGHT0(2), .WEIGHT1(1)) dut (
    .clk                  (clk),
    .reset                (reset),
    .fifo0_empty          (fifo0_empty),
    .fifo1_empty          (fifo1_empty),
    .in0                  (in0),
    .in1                  (in1),
    .fifo_down_almostfull (af),
    .pop_0                (pop_0),
    .pop_1                (pop_1),
    .push                 (push),
    .out                  (out),
    .active               (active)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles; the next tick is the first edge that samples reset=1.
  task automatic do_reset;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    fifo0_empty = 1'b0; fifo1_empty = 1'b0; af = 1'b0;
    in0 = 10'h0A0; in1 = 10'h1B1;
    reset = 1'b0;
    repeat (3) tick();
    n_tests++; if (pop_0 !== 1'b0) begin n_fail++; $display("FAIL reset_pop0 got %b want 0", pop_0); end
    n_tests++; if (pop_1 !== 1'b0) begin n_fail++; $display("FAIL reset_pop1 got %b want 0", pop_1); end
    n_tests++; if (push !== 1'b0) begin n_fail++; $display("FAIL reset_push got %b want 0", push); end
    n_tests++; if (out !== 10'h000) begin n_fail++; $display("FAIL reset_out got %h want 000", out); end
    n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", active); end
    reset = 1'b1;
    tick();
    n_tests++; if (pop_0 !== 1'b0 || pop_1 !== 1'b0) begin n_fail++; $display("FAIL reset_first_cycle_pop got %b%b want 00", pop_1, pop_0); end
    n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL reset_first_active got %b want 1", active); end
    tick();
    n_tests++; if (pop_0 !== 1'b1) begin n_fail++; $display("FAIL reset_first_pop0 got %b want 1", pop_0); end
  endtask

  task automatic test_weighting;
    logic exp_p1, exp_src;
    fifo0_empty = 1'b0; fifo1_empty = 1'b0; af = 1'b0;
    in0 = 10'h0A0; in1 = 10'h1B1;
    do_reset();
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_p1 = ((i - 1) % 3 == 2);
      n_tests++; if (pop_0 !== !exp_p1 || pop_1 !== exp_p1) begin n_fail++; $display("FAIL weight_pop[%0d] got %b%b want %b%b", i, pop_1, pop_0, exp_p1, !exp_p1); end
      if (i >= 3) begin
        exp_src = ((i - 3) % 3 == 2);
        n_tests++; if (push !== 1'b1 || out !== (exp_src ? 10'h1B1 : 10'h0A0)) begin n_fail++; $display("FAIL weight_push[%0d] got push=%b out=%h want push=1 out=%h", i, push, out, exp_src ? 10'h1B1 : 10'h0A0); end
      end else begin
        n_tests++; if (push !== 1'b0) begin n_fail++; $display("FAIL weight_nopush[%0d] got %b want 0", i, push); end
      end
    end
  endtask

  task automatic test_single_vc;
    fifo0_empty = 1'b0; fifo1_empty = 1'b1; af = 1'b0;
    in0 = 10'h055; in1 = 10'h3FF;
    do_reset();
    tick();
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_tests++; if (pop_0 !== 1'b1 || pop_1 !== 1'b0) begin n_fail++; $display("FAIL single_pop[%0d] got %b%b want 01", i, pop_1, pop_0); end
    end
    fifo0_empty = 1'b1;
    tick();
    n_tests++; if (pop_0 !== 1'b0 || active !== 1'b0) begin n_fail++; $display("FAIL single_idle got pop0=%b active=%b want 0 0", pop_0, active); end
    tick();
    n_tests++; if (push !== 1'b1 || out !== 10'h055) begin n_fail++; $display("FAIL single_last_push got push=%b out=%h want 1 055", push, out); end
    tick();
    n_tests++; if (push !== 1'b0 || out !== 10'h055) begin n_fail++; $display("FAIL single_hold got push=%b out=%h want 0 055", push, out); end
  endtask

  task automatic test_backpressure;
    int pushes;
    fifo0_empty = 1'b0; fifo1_empty = 1'b0; af = 1'b0;
    in0 = 10'h0A0; in1 = 10'h1B1;
    do_reset();
    tick();
    repeat (4) tick();
    af = 1'b1;
    pushes = 0;
    for (int i = 5; i <= 8; i++) begin
      tick();
      n_tests++; if (pop_0 !== 1'b0 || pop_1 !== 1'b0 || active !== 1'b1) begin n_fail++; $display("FAIL bp_stall[%0d] got pops=%b%b active=%b want 00 1", i, pop_1, pop_0, active); end
      if (push === 1'b1) pushes++;
    end
    n_tests++; if (pushes != 2) begin n_fail++; $display("FAIL bp_trailing_pushes got %0d want 2", pushes); end
    n_tests++; if (out !== 10'h0A0) begin n_fail++; $display("FAIL bp_out got %h want 0A0", out); end
    af = 1'b0;
    tick();
    n_tests++; if (pop_0 !== 1'b1 || pop_1 !== 1'b0) begin n_fail++; $display("FAIL bp_resume got %b%b want 01", pop_1, pop_0); end
    tick();
    n_tests++; if (pop_0 !== 1'b0 || pop_1 !== 1'b1) begin n_fail++; $display("FAIL bp_credit_held got %b%b want 10", pop_1, pop_0); end
  endtask

  task automatic test_alternation;
    fifo0_empty = 1'b0; fifo1_empty = 1'b1; af = 1'b0;
    in0 = 10'h0A0; in1 = 10'h1B1;
    do_reset();
    tick();
    tick();
    n_tests++; if (pop_0 !== 1'b1) begin n_fail++; $display("FAIL alt_first_pop0 got %b want 1", pop_0); end
    fifo0_empty = 1'b1;
    tick();
    n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL alt_idle got active=%b want 0", active); end
    tick();
    fifo0_empty = 1'b0; fifo1_empty = 1'b0;
    tick();
    n_tests++; if (active !== 1'b1 || pop_0 !== 1'b0 || pop_1 !== 1'b0) begin n_fail++; $display("FAIL alt_enter got active=%b pops=%b%b want 1 00", active, pop_1, pop_0); end
    tick();
    n_tests++; if (pop_1 !== 1'b1 || pop_0 !== 1'b0) begin n_fail++; $display("FAIL alt_vc1_first got %b%b want 10", pop_1, pop_0); end
  endtask

  task automatic test_reset_mid;
    fifo0_empty = 1'b0; fifo1_empty = 1'b0; af = 1'b0;
    in0 = 10'h0A0; in1 = 10'h1B1;
    do_reset();
    tick();
    repeat (3) tick();
    n_tests++; if (pop_1 !== 1'b1) begin n_fail++; $display("FAIL mid_pop1 got %b want 1", pop_1); end
    tick();
    n_tests++; if (push !== 1'b1 || out !== 10'h0A0) begin n_fail++; $display("FAIL mid_push got push=%b out=%h want 1 0A0", push, out); end
    reset = 1'b0;
    tick();
    n_tests++; if (push !== 1'b0 || out !== 10'h000 || pop_0 !== 1'b0 || pop_1 !== 1'b0 || active !== 1'b0) begin n_fail++; $display("FAIL mid_reset got push=%b out=%h pops=%b%b active=%b want all 0", push, out, pop_1, pop_0, active); end
    reset = 1'b1;
    tick();
    n_tests++; if (push !== 1'b0 || pop_0 !== 1'b0 || pop_1 !== 1'b0) begin n_fail++; $display("FAIL mid_after got push=%b pops=%b%b want 0 00", push, pop_1, pop_0); end
    tick();
    n_tests++; if (pop_0 !== 1'b1 || push !== 1'b0) begin n_fail++; $display("FAIL mid_restart got pop0=%b push=%b want 1 0", pop_0, push); end
  endtask

  initial begin
    reset = 1'b0; fifo0_empty = 1'b1; fifo1_empty = 1'b1; af = 1'b0;
    in0 = '0; in1 = '0;
    test_reset();
    test_weighting();
    test_single_vc();
    test_backpressure();
    test_alternation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
